// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: turns an execute-stage load/store into a single
// req/rvalid data-bus transaction, aligns and extends load data for
// writeback, and holds the pipeline while the access is in flight.
module miriscv_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            lsu_kill_i,
    output logic            lsu_stall_o,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_misalign_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // funct3 encodings of the supported access sizes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    state_e      state_q;
    logic        kill_q;     // current transaction was flushed; drain without done
    logic [1:0]  off_q;      // byte offset of the access within the word
    logic [2:0]  size_q;     // funct3 of the outstanding access

    logic            illegal;
    logic            accept;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Decode legality, byte enables and lane-replicated store data for the incoming access
    always_comb begin
        illegal    = 1'b0;
        be_next    = 4'b1111;
        wdata_next = lsu_wdata_i;
        case (lsu_size_i)
            SZ_B, SZ_BU: begin
                be_next    = 4'b0001 << lsu_addr_i[1:0];
                wdata_next = {4{lsu_wdata_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                illegal    = lsu_addr_i[0];
                be_next    = 4'b0011 << lsu_addr_i[1:0];
                wdata_next = {2{lsu_wdata_i[15:0]}};
            end
            SZ_W: illegal = (lsu_addr_i[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
        // unsigned variants exist only for loads
        if (lsu_we_i && lsu_size_i[2])
            illegal = 1'b1;
    end

    assign accept         = (state_q == IDLE) && lsu_req_i && !illegal && !lsu_kill_i;
    assign lsu_misalign_o = (state_q == IDLE) && lsu_req_i && illegal;
    assign lsu_stall_o    = accept || ((state_q == WAIT) && (!kill_q || lsu_req_i));

    // Align the returned word to the accessed byte/half and extend it
    always_comb begin
        shifted   = data_rdata_i >> {off_q, 3'b000};
        load_data = shifted;
        case (size_q)
            SZ_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            SZ_BU:   load_data = {24'd0, shifted[7:0]};
            SZ_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Transaction FSM with registered bus and writeback outputs
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            kill_q       <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 3'b000;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            lsu_done_o   <= 1'b0;
            lsu_rdata_o  <= '0;
        end else begin
            lsu_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_req_o   <= 1'b1;
                        data_we_o    <= lsu_we_i;
                        data_be_o    <= be_next;
                        data_addr_o  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                        data_wdata_o <= wdata_next;
                        off_q        <= lsu_addr_i[1:0];
                        size_q       <= lsu_size_i;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (lsu_kill_i)
                        kill_q <= 1'b1;
                    if (data_rvalid_i) begin
                        data_req_o <= 1'b0;
                        kill_q     <= 1'b0;
                        // a kill arriving with rvalid still suppresses completion
                        if (kill_q || lsu_kill_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= DONE;
                            lsu_done_o <= 1'b1;
                            if (!data_we_o)
                                lsu_rdata_o <= load_data;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_kill_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misalign_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    // values captured while an access sits in WAIT
    logic [3:0]  obs_be;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic        obs_req;
    logic        done_seen;

    miriscv_lsu #(.XLEN(32)) dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_size_i    (lsu_size_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_kill_i    (lsu_kill_i),
        .lsu_stall_o   (lsu_stall_o),
        .lsu_done_o    (lsu_done_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_misalign_o(lsu_misalign_o),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Move to the next falling edge and let combinational outputs settle
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    // One complete access: present it, capture bus outputs in WAIT, answer after
    // 'waits' extra cycles, and return with the DUT in the cycle after rvalid.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        @(negedge clk_i);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        #1;
        obs_be    = data_be_o;
        obs_addr  = data_addr_o;
        obs_wdata = data_wdata_o;
        obs_we    = data_we_o;
        obs_req   = data_req_o;
        repeat (waits) @(negedge clk_i);
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        #1;
    endtask

    initial begin
        arstn_i       = 1'b0;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'b010;
        lsu_addr_i    = 32'h0;
        lsu_wdata_i   = 32'h0;
        lsu_kill_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;

        // ---- reset state ----
        step();
        check("rst data_req", 32'(data_req_o), 32'h0);
        check("rst be", 32'(data_be_o), 32'h0);
        check("rst addr", data_addr_o, 32'h0);
        check("rst rdata", lsu_rdata_o, 32'h0);
        check("rst stall", 32'(lsu_stall_o), 32'h0);
        arstn_i = 1'b1;

        // ---- LW 0x1000, two wait cycles ----
        step();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_1000;
        #1;
        check("lw accept stall", 32'(lsu_stall_o), 32'h1);
        check("lw idle no req", 32'(data_req_o), 32'h0);
        step();                                         // WAIT, wait cycle 1
        check("lw req c1", 32'(data_req_o), 32'h1);
        check("lw be", 32'(data_be_o), 32'hF);
        check("lw addr", data_addr_o, 32'h0000_1000);
        check("lw we", 32'(data_we_o), 32'h0);
        check("lw stall wait", 32'(lsu_stall_o), 32'h1);
        step();                                         // wait cycle 2
        check("lw req c2", 32'(data_req_o), 32'h1);
        check("lw no done yet", 32'(lsu_done_o), 32'h0);
        step();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("lw req c3", 32'(data_req_o), 32'h1);
        step();                                         // DONE, request still held
        data_rvalid_i = 1'b0;
        check("lw done", 32'(lsu_done_o), 32'h1);
        check("lw rdata", lsu_rdata_o, 32'hDEAD_BEEF);
        check("lw req dropped", 32'(data_req_o), 32'h0);
        check("lw done no stall", 32'(lsu_stall_o), 32'h0);
        step();                                         // back in IDLE
        lsu_req_i = 1'b0;
        #1;
        check("lw done pulse one", 32'(lsu_done_o), 32'h0);
        check("lw no reissue", 32'(data_req_o), 32'h0);

        // ---- LB / LBU at 0x1003 ----
        access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
        check("lb be", 32'(obs_be), 32'h8);
        check("lb addr", obs_addr, 32'h0000_1000);
        check("lb done", 32'(lsu_done_o), 32'h1);
        check("lb rdata", lsu_rdata_o, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
        check("lbu be", 32'(obs_be), 32'h8);
        check("lbu rdata", lsu_rdata_o, 32'h0000_0080);

        // ---- LH at 0x1002: sign-extended upper half ----
        access(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 1);
        check("lh be", 32'(obs_be), 32'hC);
        check("lh rdata", lsu_rdata_o, 32'hFFFF_8001);

        // ---- SH 0x2002 ----
        access(1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h1234_9876, 0);
        check("lhu rdata", lsu_rdata_o, 32'h0000_9876);
        access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
        check("sh req", 32'(obs_req), 32'h1);
        check("sh be", 32'(obs_be), 32'hC);
        check("sh wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh we", 32'(obs_we), 32'h1);
        check("sh addr", obs_addr, 32'h0000_2000);
        check("sh done", 32'(lsu_done_o), 32'h1);
        check("sh rdata kept", lsu_rdata_o, 32'h0000_9876);

        // ---- SB 0x3001: byte replicated on every lane ----
        access(1'b1, 3'b000, 32'h0000_3001, 32'h0000_005A, 32'h0, 0);
        check("sb be", 32'(obs_be), 32'h2);
        check("sb wdata", obs_wdata, 32'h5A5A_5A5A);

        // ---- illegal accesses ----
        step();
        step();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_1001;
        #1;
        check("lw mis flag", 32'(lsu_misalign_o), 32'h1);
        check("lw mis stall", 32'(lsu_stall_o), 32'h0);
        step();
        check("lw mis no req", 32'(data_req_o), 32'h0);
        lsu_size_i = 3'b001;
        lsu_addr_i = 32'h0000_1003;
        #1;
        check("lh mis flag", 32'(lsu_misalign_o), 32'h1);
        check("lh mis stall", 32'(lsu_stall_o), 32'h0);
        step();
        check("lh mis no req", 32'(data_req_o), 32'h0);
        lsu_size_i = 3'b011;
        lsu_addr_i = 32'h0000_1000;
        #1;
        check("size011 flag", 32'(lsu_misalign_o), 32'h1);
        check("size011 stall", 32'(lsu_stall_o), 32'h0);
        lsu_we_i   = 1'b1;
        lsu_size_i = 3'b100;
        #1;
        check("sbu flag", 32'(lsu_misalign_o), 32'h1);
        step();
        check("illegal no req", 32'(data_req_o), 32'h0);
        lsu_req_i = 1'b0;
        lsu_we_i  = 1'b0;
        #1;
        check("no req no flag", 32'(lsu_misalign_o), 32'h0);

        // ---- kill in IDLE blocks acceptance ----
        step();
        lsu_req_i  = 1'b1;
        lsu_kill_i = 1'b1;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_3000;
        #1;
        check("idle kill stall", 32'(lsu_stall_o), 32'h0);
        step();
        check("idle kill no req", 32'(data_req_o), 32'h0);

        // ---- kill while in WAIT, new request held during drain ----
        lsu_kill_i = 1'b0;
        done_seen  = 1'b0;
        step();                                         // WAIT for 0x3000
        lsu_kill_i = 1'b1;
        lsu_addr_i = 32'h0000_4000;
        #1;
        check("kill req up", 32'(data_req_o), 32'h1);
        step();                                         // flag set, new request held
        lsu_kill_i = 1'b0;
        #1;
        done_seen = done_seen | lsu_done_o;
        check("drain stall", 32'(lsu_stall_o), 32'h1);
        check("drain req held", 32'(data_req_o), 32'h1);
        check("drain addr held", data_addr_o, 32'h0000_3000);
        step();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        #1;
        done_seen = done_seen | lsu_done_o;
        step();                                         // IDLE, new request accepted now
        data_rvalid_i = 1'b0;
        #1;
        done_seen = done_seen | lsu_done_o;
        check("kill no done", 32'(done_seen), 32'h0);
        check("kill req dropped", 32'(data_req_o), 32'h0);
        check("kill rdata kept", lsu_rdata_o, 32'h5A5A_5A5A & 32'h0 | 32'h0000_9876);
        check("kill reaccept stall", 32'(lsu_stall_o), 32'h1);
        step();
        lsu_req_i = 1'b0;
        #1;
        check("new req", 32'(data_req_o), 32'h1);
        check("new addr", data_addr_o, 32'h0000_4000);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h55AA_55AA;
        step();
        data_rvalid_i = 1'b0;
        check("new done", 32'(lsu_done_o), 32'h1);
        check("new rdata", lsu_rdata_o, 32'h55AA_55AA);

        // ---- reset in WAIT ----
        step();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b1;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_5000;
        lsu_wdata_i = 32'hCAFE_F00D;
        step();
        lsu_req_i = 1'b0;
        check("pre-rst req", 32'(data_req_o), 32'h1);
        arstn_i = 1'b0;
        #1;
        check("rst mid req", 32'(data_req_o), 32'h0);
        check("rst mid we", 32'(data_we_o), 32'h0);
        check("rst mid wdata", data_wdata_o, 32'h0);
        check("rst mid rdata", lsu_rdata_o, 32'h0);
        step();
        arstn_i = 1'b1;
        step();
        check("post-rst req", 32'(data_req_o), 32'h0);
        check("post-rst be", 32'(data_be_o), 32'h0);
        check("post-rst addr", data_addr_o, 32'h0);
        check("post-rst done", 32'(lsu_done_o), 32'h0);
        check("post-rst stall", 32'(lsu_stall_o), 32'h0);
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h0000_6000;
        #1;
        check("post-rst idle accept", 32'(lsu_stall_o), 32'h1);
        step();
        lsu_req_i = 1'b0;
        check("post-rst new req", 32'(data_req_o), 32'h1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0;
        step();
        data_rvalid_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load/store unit in the miriscv execute stage, directly downstream of the ALU.
- Consumes the ALU adder output as the effective address, plus the store operand from the register file.
- Runs one data-memory transaction at a time over a req/rvalid bus.
- Returns aligned, sign/zero-extended load data to writeback and stalls the pipeline while a transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk_i  input  1  core clock
- arstn_i  input  1  asynchronous active-low reset
- lsu_req_i  input  1  execute stage holds a valid load/store; held high while lsu_stall_o=1
- lsu_we_i  input  1  1=store, 0=load
- lsu_size_i  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  input  XLEN  effective address (ALU adder output)
- lsu_wdata_i  input  XLEN  store data (rs2)
- lsu_kill_i  input  1  pipeline flush for the current instruction
- lsu_stall_o  output  1  hold the pipeline
- lsu_done_o  output  1  one-cycle pulse: access complete
- lsu_rdata_o  output  XLEN  extended load result, valid with lsu_done_o
- lsu_misalign_o  output  1  combinational exception flag: misaligned or illegal access
- data_req_o  output  1  bus request
- data_we_o  output  1  bus write enable
- data_be_o  output  4  byte enables
- data_addr_o  output  XLEN  word-aligned bus address
- data_wdata_o  output  XLEN  lane-replicated store data
- data_rvalid_i  input  1  bus response; completes the request
- data_rdata_i  input  XLEN  bus read data

Behaviour:
- Reset (arstn_i low, asynchronous):
  - FSM goes to IDLE; kill flag is cleared.
  - Every registered output is 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_done_o, lsu_rdata_o.
  - A reset mid-transaction abandons the transaction; data_req_o drops immediately.
- FSM states: IDLE, WAIT, DONE.
- Illegal access, checked combinationally in IDLE:
  - size 011, 110, 111, or a store with size[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
  - On an illegal access, lsu_misalign_o=1 while lsu_req_i=1 in IDLE. No bus request is made and no stall is raised. lsu_misalign_o is 0 in WAIT/DONE.
- Accept condition: IDLE & lsu_req_i & legal & !lsu_kill_i. On accept, the next edge:
  - registers data_addr_o = {addr[31:2],2'b00} and data_we_o;
  - registers data_be_o: B=0001<<addr[1:0], H=0011<<addr[1:0], W=1111 (same value for loads);
  - registers data_wdata_o: B={4{wdata[7:0]}}, H={2{wdata[15:0]}}, W=wdata;
  - latches offset addr[1:0] and size;
  - sets data_req_o=1 and moves to WAIT.
- WAIT:
  - data_req_o and all bus outputs are held stable until data_rvalid_i=1. Zero or more wait cycles are allowed.
  - On rvalid the next edge: data_req_o=0.
  - If the kill flag is clear: move to DONE, pulse lsu_done_o=1 for one cycle.
  - For loads: lsu_rdata_o = data_rdata_i >> (8*offset), then sign-extend from bit 7 (B) or 15 (H), zero-extend for BU/HU, or pass through (W).
  - For stores: lsu_rdata_o holds its previous value.
- DONE: lsu_stall_o=0 so the pipeline advances; lsu_req_i is ignored this cycle (no reissue); return to IDLE.
- lsu_stall_o = accept condition | (WAIT & !killed) | (WAIT & killed & lsu_req_i). It is combinational.
- Latency: accept at cycle N, data_req_o from N+1, rvalid at M≥N+1, lsu_done_o and lsu_rdata_o at M+1. Minimum 3 cycles per access; back-to-back accesses lose one cycle in DONE.
- Kill handling:
  - lsu_kill_i in IDLE blocks acceptance.
  - lsu_kill_i in WAIT sets the kill flag. The bus transaction still completes (no abort), then the FSM returns to IDLE with no lsu_done_o and lsu_rdata_o unchanged.
  - A new request arriving while draining stalls until IDLE.
  - The kill flag clears on leaving WAIT.
- Simultaneous events: lsu_kill_i together with rvalid in WAIT is treated as killed (no done).

Test Plan:
- LW addr 0x1000, rvalid after 2 wait cycles with rdata 0xDEADBEEF -> data_req_o high 3 cycles, be=1111, addr=0x1000; lsu_done_o=1 and lsu_rdata_o=0xDEADBEEF one cycle after rvalid; stall drops in DONE.
- LB/LBU addr 0x1003 with rdata 0x80FF_0000 -> be=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x2002, wdata 0x1234ABCD -> be=1100, data_wdata_o=0xABCDABCD, data_we_o=1; lsu_rdata_o unchanged.
- LW addr 0x1001, and LH addr 0x1003 -> lsu_misalign_o=1, data_req_o stays 0, lsu_stall_o=0. Size 011 -> same result.
- LW accepted, lsu_kill_i pulsed in WAIT, rvalid 2 cycles later -> bus completes; lsu_done_o never asserts; FSM returns to IDLE; a new request held during the drain is accepted on the first IDLE cycle.
- arstn_i asserted while in WAIT -> data_req_o=0 immediately; after release the FSM is IDLE and all outputs are 0.
